fifo_rd_axis_bridge: RTL



---
 rtl/fifo_rd_axis_pkg.sv | 16 +
 rtl/axis_skid_buf.sv | 99 +++++++++
 rtl/fifo_rd_axis_bridge.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fifo_rd_axis_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_axis_pkg
// Shared helpers for the FIFO-reader to AXI4-Stream bridge.
//   beat_cnt_w(pkt_len) : width of the per-packet beat counter, sized so that
//                         it can hold the value pkt_len.
// The tagged beat ({last, data}) is declared inside the bridge, where the data
// width parameter is in scope.
// -----------------------------------------------------------------------------
package fifo_rd_axis_pkg;

  // Width of the beat counter for a given packet length.
  function automatic int beat_cnt_w(input int pkt_len);
    return $clog2(pkt_len + 1);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// -----------------------------------------------------------------------------
// axis_skid_buf
// Two-entry stream buffer: an output register plus one skid register.
// in_ready depends only on the skid flag, so there is no combinational path
// from m_ready back to the upstream source.
//
// Ports
//   clk       : clock, all logic on posedge
//   reset     : asynchronous active-high reset, clears both valid flags
//   in_valid  : upstream word available
//   in_ready  : buffer can accept a word this cycle (skid register empty)
//   in_data   : upstream word, taken when in_valid & in_ready
//   m_valid   : output register holds a word
//   m_ready   : downstream accepts the output word
//   m_data    : output word, held stable until accepted
// -----------------------------------------------------------------------------
module axis_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
);

  logic          out_v_q, out_v_d;
  logic          skid_v_q, skid_v_d;
  logic [DW-1:0] out_data_q;
  logic [DW-1:0] skid_data_q;
  logic          push_s;
  logic          xfer_s;
  logic          ld_out_skid_s;
  logic          ld_out_in_s;
  logic          ld_skid_s;

  assign in_ready = ~skid_v_q;
  assign push_s   = in_valid & ~skid_v_q;
  assign xfer_s   = out_v_q & m_ready;
  assign m_valid  = out_v_q;
  assign m_data   = out_data_q;

  // Next-state selection; the order of the branches is the priority order.
  always_comb begin
    out_v_d       = out_v_q;
    skid_v_d      = skid_v_q;
    ld_out_skid_s = 1'b0;
    ld_out_in_s   = 1'b0;
    ld_skid_s     = 1'b0;
    if (skid_v_q && xfer_s) begin
      // Skid drains first; push is impossible here because in_ready is low.
      ld_out_skid_s = 1'b1;
      skid_v_d      = 1'b0;
    end else if (push_s && (!out_v_q || xfer_s)) begin
      ld_out_in_s = 1'b1;
      out_v_d     = 1'b1;
    end else if (push_s) begin
      // Output is stalled: the word popped this cycle parks in the skid.
      ld_skid_s = 1'b1;
      skid_v_d  = 1'b1;
    end else if (xfer_s) begin
      out_v_d = 1'b0;
    end else begin
      out_v_d  = out_v_q;
      skid_v_d = skid_v_q;
    end
  end

  // Valid flags, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  // Data registers carry no reset; they are qualified by the valid flags.
  always_ff @(posedge clk) begin
    if (ld_out_skid_s) begin
      out_data_q <= skid_data_q;
    end else if (ld_out_in_s) begin
      out_data_q <= in_data;
    end else begin
      out_data_q <= out_data_q;
    end
    if (ld_skid_s) begin
      skid_data_q <= in_data;
    end else begin
      skid_data_q <= skid_data_q;
    end
  end

endmodule

// File: rtl/fifo_rd_axis_bridge.sv
// -----------------------------------------------------------------------------
// fifo_rd_axis_bridge
// Pops words from a first-word-fall-through FIFO and presents them as an
// AXI4-Stream master through a two-entry output buffer (axis_skid_buf).
//
// Build option: define FIFO_RD_AXIS_TLAST_EN to enable the packet counter and
// tlast generation (every PKT_LEN-th beat). Without it, beat_cnt is tied to 0,
// m_tlast is tied to 1 and the buffer carries only the data word.
//
// Ports
//   clk      : clock, all logic on posedge
//   reset    : asynchronous active-high reset (the FIFO shares it)
//   rd_empty : FIFO empty flag; rd_data valid when low
//   rd_data  : FIFO head word (fall-through)
//   rd_en    : FIFO pop strobe; independent of m_tready
//   m_tvalid : stream valid
//   m_tready : stream ready
//   m_tdata  : stream data
//   m_tlast  : end-of-packet marker
//   beat_cnt : beats already popped in the current packet
// -----------------------------------------------------------------------------
module fifo_rd_axis_bridge
  import fifo_rd_axis_pkg::*;
#(
  parameter int W       = 8,
  parameter int PKT_LEN = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rd_empty,
  input  logic [W-1:0]                    rd_data,
  output logic                            rd_en,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [W-1:0]                    m_tdata,
  output logic                            m_tlast,
  output logic [beat_cnt_w(PKT_LEN)-1:0]  beat_cnt
);

  localparam int CW = beat_cnt_w(PKT_LEN);

  logic src_valid_s;
  logic buf_ready_s;

  // Pop needs a word at the FIFO head and a free skid slot; m_tready is not
  // involved, which keeps the ready path registered.
  assign src_valid_s = ~reset & ~rd_empty;
  assign rd_en       = src_valid_s & buf_ready_s;

`ifdef FIFO_RD_AXIS_TLAST_EN

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  beat_t         in_beat_s;
  beat_t         out_beat_s;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          last_s;

  assign last_s    = (beat_cnt_q == CW'(PKT_LEN - 1));
  assign in_beat_s = {last_s, rd_data};

  // Beat counter advances on every pop and wraps on the last beat.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (rd_en) begin
      if (last_s) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CW'(1);
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  axis_skid_buf #(
    .DW ($bits(beat_t))
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (src_valid_s),
    .in_ready (buf_ready_s),
    .in_data  (in_beat_s),
    .m_valid  (m_tvalid),
    .m_ready  (m_tready),
    .m_data   (out_beat_s)
  );

  assign m_tdata  = out_beat_s.data;
  assign m_tlast  = out_beat_s.last;
  assign beat_cnt = beat_cnt_q;

`else

  axis_skid_buf #(
    .DW (W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (src_valid_s),
    .in_ready (buf_ready_s),
    .in_data  (rd_data),
    .m_valid  (m_tvalid),
    .m_ready  (m_tready),
    .m_data   (m_tdata)
  );

  // Every beat is a single-beat packet.
  assign m_tlast  = 1'b1;
  assign beat_cnt = {CW{1'b0}};

`endif

endmodule
